// File: rtl/harmonic_phase_store_if.sv
// harmonic_phase_store_if
//   Handshake bundle between the sample-generation state machine (master)
//   and the per-harmonic phase store (slave).
//   frequency       : fundamental phase increment per output sample
//   harmonic        : index of the harmonic to fetch next
//   next_sample     : single-cycle "current value consumed" pulse
//   sample_ready    : sample_position/sample_aliased valid
//   sample_position : stored (pre-advance) position of the latched harmonic
//   sample_aliased  : latched harmonic's increment is at or above Nyquist
interface harmonic_phase_store_if #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned PHASE_W = 16
);
  logic [PHASE_W-1:0] frequency;
  logic [IDX_W-1:0]   harmonic;
  logic               next_sample;
  logic               sample_ready;
  logic [PHASE_W-1:0] sample_position;
  logic               sample_aliased;

  modport master (
    output frequency, harmonic, next_sample,
    input  sample_ready, sample_position, sample_aliased
  );

  modport slave (
    input  frequency, harmonic, next_sample,
    output sample_ready, sample_position, sample_aliased
  );
endinterface

// File: rtl/harmonic_phase_store.sv
// harmonic_phase_store
//   Per-harmonic phase accumulator for the additive oscillator. One
//   PHASE_W-bit cycle position per harmonic lives in a single-port RAM with
//   registered output. The latched harmonic's position is presented with a
//   ready/next handshake; on next_sample it is written back advanced by
//   frequency * (harmonic+1) and the next requested harmonic is fetched.
//   Ports:
//     clock : rising-edge clock
//     rstn  : asynchronous active-low reset
//     bus   : harmonic_phase_store_if.slave handshake bundle
module harmonic_phase_store #(
  parameter int unsigned HARMONICS = 256,
  parameter int unsigned PHASE_W   = 16
) (
  input  logic                    clock,
  input  logic                    rstn,
  harmonic_phase_store_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(HARMONICS);
  localparam int unsigned PROD_W = PHASE_W + IDX_W + 1;

  typedef enum logic [1:0] {CLEAR, READ, WAIT, READY} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   clr_addr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   new_idx;
  logic [PROD_W-1:0]  inc_r;
  logic [PHASE_W-1:0] pos_r;
  logic               ready_r;
  logic               aliased_r;
  logic               bypass_v;
  logic [PHASE_W-1:0] bypass_d;

  logic [PHASE_W-1:0] mem [HARMONICS];
  logic [PHASE_W-1:0] ram_q;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [PHASE_W-1:0] ram_wd;

  logic               clr_last;
  logic               accept;
  logic [IDX_W:0]     mult;
  logic [PROD_W-1:0]  inc_next;
  logic [PHASE_W-1:0] wb_data;

  assign clr_last = (clr_addr == IDX_W'(HARMONICS - 1));
  assign mult     = {1'b0, new_idx} + (IDX_W + 1)'(1);
  assign inc_next = PROD_W'(bus.frequency) * PROD_W'(mult);
  // Position advance wraps silently modulo 2^PHASE_W.
  assign wb_data  = pos_r + inc_r[PHASE_W-1:0];

  assign bus.sample_ready    = ready_r;
  assign bus.sample_position = pos_r;
  assign bus.sample_aliased  = aliased_r;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = new_idx;
    ram_wd     = wb_data;
    accept     = 1'b0;
    case (state)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_wd   = '0;
        if (clr_last) state_next = READ;
      end
      READ:  state_next = WAIT;
      WAIT:  state_next = READY;
      READY: begin
        ram_addr = idx;
        if (bus.next_sample) begin
          accept     = 1'b1;
          ram_we     = 1'b1;
          state_next = READ;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      clr_addr  <= '0;
      idx       <= '0;
      new_idx   <= '0;
      inc_r     <= '0;
      pos_r     <= '0;
      ready_r   <= 1'b0;
      aliased_r <= 1'b0;
      bypass_v  <= 1'b0;
      bypass_d  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + IDX_W'(1);
          bypass_v <= 1'b0;
          if (clr_last) new_idx <= bus.harmonic;
        end
        READ: inc_r <= inc_next;
        WAIT: begin
          // A write-back to the index being fetched must win over RAM data.
          pos_r     <= bypass_v ? bypass_d : ram_q;
          aliased_r <= |inc_r[PROD_W-1:PHASE_W-1];
          idx       <= new_idx;
          ready_r   <= 1'b1;
        end
        READY: begin
          if (accept) begin
            new_idx  <= bus.harmonic;
            ready_r  <= 1'b0;
            bypass_v <= (bus.harmonic == idx);
            bypass_d <= wb_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-port block RAM, registered read data. Writes happen only in CLEAR
  // and on the READY->READ edge, so the shared address never conflicts.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_harmonic_phase_store.sv
// tb_harmonic_phase_store
//   Directed bench for harmonic_phase_store: reset/clear latency, fundamental
//   advance with wrap, harmonic scaling, write-back bypass, aliasing flag,
//   x256 harmonic, zero frequency, continuous next_sample, reset mid-fetch.
module tb_harmonic_phase_store;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  harmonic_phase_store_if bus ();

  harmonic_phase_store #(.HARMONICS(256), .PHASE_W(16)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (bus.sample_ready !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Called at a negedge with sample_ready high.
  task automatic serve(input logic [7:0] h);
    int n;
    bus.harmonic    = h;
    bus.next_sample = 1'b1;
    @(negedge clock);
    bus.next_sample = 1'b0;
    chk("ready_drop", {31'd0, bus.sample_ready}, 32'd0);
    wait_ready(10, n);
    chk("turnaround", n + 1, 3);
  endtask

  task automatic rd(input string tag, input logic [15:0] p, input logic a);
    chk({tag, "_ready"}, {31'd0, bus.sample_ready}, 32'd1);
    chk({tag, "_pos"}, {16'd0, bus.sample_position}, {16'd0, p});
    chk({tag, "_alias"}, {31'd0, bus.sample_aliased}, {31'd0, a});
  endtask

  // Release reset at a negedge, poke next_sample during CLEAR and READ,
  // and time the first sample_ready.
  task automatic release_and_time();
    int n;
    rstn = 1'b1;
    n = 0;
    while (bus.sample_ready !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
      bus.next_sample = (n == 100 || n == 256);
    end
    bus.next_sample = 1'b0;
    chk("reset_latency", n, 258);
  endtask

  initial begin
    int rc;
    bus.frequency   = 16'd1000;
    bus.harmonic    = 8'd0;
    bus.next_sample = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, bus.sample_ready}, 32'd0);
    chk("rst_pos", {16'd0, bus.sample_position}, 32'd0);
    chk("rst_alias", {31'd0, bus.sample_aliased}, 32'd0);
    release_and_time();

    // Fundamental: 0, 1000, ..., 65000, then 464 after wrap.
    for (int i = 0; i < 70; i++) begin
      chk("fund_pos", {16'd0, bus.sample_position}, (i * 1000) % 65536);
      serve(8'd0);
    end
    rd("fund_end", 16'd4464, 1'b0);

    // Harmonic scaling: 4 (x5) and 21 (x6*... x22) alternating.
    serve(8'd4);  rd("h4_a", 16'd0, 1'b0);
    serve(8'd21); rd("h21_a", 16'd0, 1'b0);
    serve(8'd4);  rd("h4_b", 16'd5000, 1'b0);
    serve(8'd21); rd("h21_b", 16'd22000, 1'b0);
    serve(8'd4);  rd("h4_c", 16'd10000, 1'b0);
    serve(8'd21); rd("h21_c", 16'd44000, 1'b0);

    // Bypass: repeated fetch of the same index sees the fresh write.
    bus.frequency = 16'd300;
    serve(8'd7); rd("byp_a", 16'd0, 1'b0);
    serve(8'd7); rd("byp_b", 16'd2400, 1'b0);
    serve(8'd7); rd("byp_c", 16'd4800, 1'b0);

    // Aliasing; harmonic 7 keeps its x300 increment fetched earlier.
    bus.frequency = 16'd2000;
    serve(8'd15);  rd("al15_a", 16'd0, 1'b0);
    serve(8'd16);  rd("al16_a", 16'd0, 1'b1);
    serve(8'd16);  rd("al16_b", 16'd34000, 1'b1);
    serve(8'd15);  rd("al15_b", 16'd32000, 1'b0);
    serve(8'd16);  rd("al16_c", 16'd2464, 1'b1);
    serve(8'd7);   rd("h7_wb", 16'd7200, 1'b0);
    serve(8'd21);  rd("h21_wrap", 16'd464, 1'b1);
    serve(8'd255); rd("h255_a", 16'd0, 1'b1);
    serve(8'd255); rd("h255_b", 16'd53248, 1'b1);

    // Zero frequency: position frozen.
    bus.frequency = 16'd0;
    serve(8'd100); rd("f0_a", 16'd0, 1'b0);
    serve(8'd100); rd("f0_b", 16'd0, 1'b0);

    // Continuous next_sample for 20 edges on harmonic 0 (+10 per accept).
    bus.frequency = 16'd10;
    serve(8'd0); rd("abuse_pre", 16'd5464, 1'b0);
    bus.harmonic    = 8'd0;
    bus.next_sample = 1'b1;
    rc = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.sample_ready === 1'b1) rc++;
      @(negedge clock);
    end
    bus.next_sample = 1'b0;
    chk("abuse_ready_cnt", rc, 7);
    wait_ready(10, rc);
    rd("abuse_post", 16'd5534, 1'b0);

    // Reset asserted in WAIT aborts nothing already committed but clears all.
    bus.harmonic    = 8'd3;
    bus.next_sample = 1'b1;
    @(negedge clock);
    bus.next_sample = 1'b0;
    @(negedge clock);
    rstn = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.sample_ready}, 32'd0);
    chk("midrst_pos", {16'd0, bus.sample_position}, 32'd0);
    @(negedge clock);
    bus.harmonic = 8'd0;
    release_and_time();
    rd("clr_h0", 16'd0, 1'b0);
    serve(8'd21);  rd("clr_h21", 16'd0, 1'b0);
    serve(8'd16);  rd("clr_h16", 16'd0, 1'b0);
    serve(8'd255); rd("clr_h255", 16'd0, 1'b0);
    serve(8'd7);   rd("clr_h7", 16'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
